// File: rtl/seg_capture.sv
// seg_capture: watches a multiplexed seven-segment scan and rebuilds the 32-bit word being
// shown. Every digit must hold steady for STABLE_CYCLES clocks before it is decoded and
// written into the word. A frame completes once all eight digits have been captured.
module seg_capture #(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned CNT_W         = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [2:0]  which,
   input  logic [7:0]  seg,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        data_changed,
   output logic        code_err,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {StWait, StSettle, StHeld} state_e;

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   // Active-low pattern to {legal, nibble}; dp (bit 0) must be off.
   function automatic logic [4:0] decode_seg(input logic [7:0] s);
      logic [4:0] r;
      unique case (s)
         8'h03:   r = 5'h10;
         8'h9F:   r = 5'h11;
         8'h25:   r = 5'h12;
         8'h0D:   r = 5'h13;
         8'h99:   r = 5'h14;
         8'h49:   r = 5'h15;
         8'h41:   r = 5'h16;
         8'h1F:   r = 5'h17;
         8'h01:   r = 5'h18;
         8'h09:   r = 5'h19;
         8'h11:   r = 5'h1A;
         8'hC1:   r = 5'h1B;
         8'h63:   r = 5'h1C;
         8'h85:   r = 5'h1D;
         8'h61:   r = 5'h1E;
         8'h71:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   // Input sample stage
   logic       en_q;
   logic [2:0] which_q;
   logic [7:0] seg_q;

   state_e             state_q, state_d;
   logic [2:0]         prev_which_q, prev_which_d;
   logic [7:0]         prev_seg_q, prev_seg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               latch;

   logic [31:0] asm_q, asm_d;
   logic [7:0]  seen_q, seen_d;
   logic [31:0] data_out_q, data_out_d;
   logic        data_valid_q, data_valid_d;
   logic        data_changed_q, data_changed_d;
   logic        code_err_q, code_err_d;
   logic [7:0]  err_count_q, err_count_d;

   logic        sample_diff;
   logic [4:0]  dec;
   logic [4:0]  nib_lsb;

   assign sample_diff = (which_q != prev_which_q) || (seg_q != prev_seg_q);
   assign dec         = decode_seg(prev_seg_q);
   // which=0 is the leftmost digit, so the nibble LSB is 4*(7-which).
   assign nib_lsb     = {~prev_which_q, 2'b00};

   // Settle FSM next state: a pattern must sit unchanged for STABLE_CYCLES to latch once.
   always_comb begin
      state_d      = state_q;
      prev_which_d = prev_which_q;
      prev_seg_d   = prev_seg_q;
      cnt_d        = cnt_q;
      latch        = 1'b0;
      unique case (state_q)
         StWait: begin
            if (en_q) begin
               prev_which_d = which_q;
               prev_seg_d   = seg_q;
               cnt_d        = CntOne;
               state_d      = StSettle;
            end
         end
         StSettle: begin
            if (!en_q) begin
               state_d = StWait;
            end else if (sample_diff) begin
               prev_which_d = which_q;
               prev_seg_d   = seg_q;
               cnt_d        = CntOne;
            end else if (cnt_q >= CntMax - CntOne) begin
               cnt_d   = CntMax;
               latch   = 1'b1;
               state_d = StHeld;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StHeld: begin
            if (!en_q) begin
               state_d = StWait;
            end else if (sample_diff) begin
               prev_which_d = which_q;
               prev_seg_d   = seg_q;
               cnt_d        = CntOne;
               state_d      = StSettle;
            end
         end
         default: state_d = StWait;
      endcase
   end

   // Word assembly, frame completion and error accounting.
   always_comb begin
      asm_d          = asm_q;
      seen_d         = seen_q;
      data_out_d     = data_out_q;
      data_valid_d   = 1'b0;
      data_changed_d = 1'b0;
      code_err_d     = 1'b0;
      err_count_d    = err_count_q;
      // Completion is one cycle after the latch that filled the frame; a new latch cannot
      // land in that cycle because settling takes STABLE_CYCLES.
      if (seen_q == 8'hFF) begin
         data_out_d     = asm_q;
         data_valid_d   = 1'b1;
         data_changed_d = (asm_q != data_out_q);
         seen_d         = 8'h00;
      end
      if (latch) begin
         if (dec[4]) begin
            asm_d[nib_lsb +: 4]  = dec[3:0];
            seen_d[prev_which_q] = 1'b1;
         end else begin
            code_err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
               err_count_d = err_count_q + 8'd1;
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q           <= 1'b0;
         which_q        <= 3'd0;
         seg_q          <= 8'h00;
         state_q        <= StWait;
         prev_which_q   <= 3'd0;
         prev_seg_q     <= 8'h00;
         cnt_q          <= '0;
         asm_q          <= 32'h0;
         seen_q         <= 8'h00;
         data_out_q     <= 32'h0;
         data_valid_q   <= 1'b0;
         data_changed_q <= 1'b0;
         code_err_q     <= 1'b0;
         err_count_q    <= 8'h00;
      end else begin
         en_q           <= enable;
         which_q        <= which;
         seg_q          <= seg;
         state_q        <= state_d;
         prev_which_q   <= prev_which_d;
         prev_seg_q     <= prev_seg_d;
         cnt_q          <= cnt_d;
         asm_q          <= asm_d;
         seen_q         <= seen_d;
         data_out_q     <= data_out_d;
         data_valid_q   <= data_valid_d;
         data_changed_q <= data_changed_d;
         code_err_q     <= code_err_d;
         err_count_q    <= err_count_d;
      end
   end

   assign data_out     = data_out_q;
   assign data_valid   = data_valid_q;
   assign data_changed = data_changed_q;
   assign code_err     = code_err_q;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: drives a scan model of the display driver and checks the
// rebuilt word, pulse counts and error counter against hand-computed values.
module tb_seg_capture;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [2:0]  which;
   logic [7:0]  seg;
   logic [31:0] data_out;
   logic        data_valid;
   logic        data_changed;
   logic        code_err;
   logic [7:0]  err_count;

   int checks;
   int errors;
   int valid_cnt;
   int chg_cnt;
   int cerr_cnt;

   seg_capture #(
      .STABLE_CYCLES (16),
      .CNT_W         (5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .which        (which),
      .seg          (seg),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .data_changed (data_changed),
      .code_err     (code_err),
      .err_count    (err_count)
   );

   initial clk = 1'b0;
   always #25 clk = ~clk;

   // Pulse counters, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (data_valid)   valid_cnt++;
         if (data_changed) chg_cnt++;
         if (code_err)     cerr_cnt++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] enc(input logic [3:0] n);
      logic [7:0] t [16];
      t = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
            8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
      return t[n];
   endfunction

   // Called at a falling edge; holds the pattern for n cycles.
   task automatic show(input logic en, input logic [2:0] w, input logic [7:0] s, input int n);
      enable = en;
      which  = w;
      seg    = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input logic en, input logic [31:0] word, input logic [7:0] mask);
      for (int d = 0; d < 8; d++) begin
         if (mask[d]) show(en, 3'(d), enc(word[31-4*d -: 4]), 64);
      end
   endtask

   task automatic idle(input int n);
      enable = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      valid_cnt = 0;
      chg_cnt   = 0;
      cerr_cnt  = 0;
      rst_n     = 1'b0;
      enable    = 1'b0;
      which     = 3'd0;
      seg       = 8'hFF;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("reset data_out", data_out, 32'h0);
      check_eq("reset data_valid", 32'(data_valid), 32'h0);
      check_eq("reset code_err", 32'(code_err), 32'h0);
      check_eq("reset err_count", 32'(err_count), 32'h0);

      // One full scan
      scan(1'b1, 32'h1234_ABCD, 8'hFF);
      check_eq("scan1 valid count", 32'(valid_cnt), 32'd1);
      check_eq("scan1 data_out", data_out, 32'h1234_ABCD);
      check_eq("scan1 changed count", 32'(chg_cnt), 32'd1);
      check_eq("scan1 code_err count", 32'(cerr_cnt), 32'd0);

      // Two more scans of the same word
      scan(1'b1, 32'h1234_ABCD, 8'hFF);
      scan(1'b1, 32'h1234_ABCD, 8'hFF);
      check_eq("scan3 valid count", 32'(valid_cnt), 32'd3);
      check_eq("scan3 changed count", 32'(chg_cnt), 32'd1);
      check_eq("scan3 data_out", data_out, 32'h1234_ABCD);
      idle(5);

      // Blank pattern on digit 2
      show(1'b1, 3'd2, 8'hFF, 20);
      check_eq("blank code_err count", 32'(cerr_cnt), 32'd1);
      check_eq("blank err_count", 32'(err_count), 32'd1);
      scan(1'b1, 32'h5678_9ABC, 8'b1111_1011);
      check_eq("digit2 missing valid", 32'(valid_cnt), 32'd3);
      show(1'b1, 3'd2, enc(4'h7), 64);
      check_eq("digit2 late valid", 32'(valid_cnt), 32'd4);
      check_eq("digit2 late data_out", data_out, 32'h5678_9ABC);
      check_eq("digit2 late changed", 32'(chg_cnt), 32'd2);
      idle(5);

      // Short glitch then a stable pattern on digit 5
      show(1'b1, 3'd5, 8'h49, 10);
      show(1'b1, 3'd5, 8'h41, 20);
      scan(1'b1, 32'h5678_9ABC, 8'b1101_1111);
      check_eq("glitch valid count", 32'(valid_cnt), 32'd5);
      check_eq("glitch data_out", data_out, 32'h5678_96BC);
      check_eq("glitch changed count", 32'(chg_cnt), 32'd3);
      check_eq("glitch code_err count", 32'(cerr_cnt), 32'd1);
      idle(5);

      // Scanning with the display disabled
      scan(1'b0, 32'h0F0F_0F0F, 8'hFF);
      check_eq("disabled valid count", 32'(valid_cnt), 32'd5);
      check_eq("disabled data_out", data_out, 32'h5678_96BC);
      check_eq("disabled code_err count", 32'(cerr_cnt), 32'd1);

      // Reset mid-frame
      scan(1'b1, 32'h9999_9999, 8'b0001_1111);
      rst_n = 1'b0;
      #1;
      check_eq("midreset data_out", data_out, 32'h0);
      check_eq("midreset err_count", 32'(err_count), 32'h0);
      @(negedge clk);
      check_eq("midreset data_valid", 32'(data_valid), 32'h0);
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      scan(1'b1, 32'hFFFF_0000, 8'hFF);
      check_eq("postreset valid count", 32'(valid_cnt), 32'd6);
      check_eq("postreset data_out", data_out, 32'hFFFF_0000);
      check_eq("postreset changed count", 32'(chg_cnt), 32'd4);
      idle(5);

      // Error counter saturation
      for (int i = 0; i < 300; i++) begin
         show(1'b1, 3'(i % 2), 8'hFF, 20);
      end
      idle(5);
      check_eq("saturated err_count", 32'(err_count), 32'hFF);
      check_eq("saturated code_err count", 32'(cerr_cnt), 32'd301);
      check_eq("saturated valid count", 32'(valid_cnt), 32'd6);
      check_eq("saturated data_out", data_out, 32'hFFFF_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
